// File: rtl/lcd_phy_8080.sv
// Write-only 8080-style parallel LCD PHY: valid/ready byte input, CS_N/WR_N strobe generation,
// plus a synchronised single-pulse detector for the panel's asynchronous frame-mark signal.
module lcd_phy_8080 #(
  parameter int unsigned TW          = 2,
  parameter int unsigned TH          = 2,
  parameter int unsigned IDLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] phy_data,
  input  logic       phy_rs,
  input  logic       phy_valid,
  output logic       phy_ready,
  output logic       phy_fmark_stb,
  output logic [7:0] lcd_d,
  output logic       lcd_rs,
  output logic       lcd_wr_n,
  output logic       lcd_cs_n,
  input  logic       lcd_fmark
);

  localparam logic [7:0] TW_LOAD   = 8'(TW - 1);
  localparam logic [7:0] TH_LOAD   = 8'(TH - 1);
  localparam logic [7:0] IDLE_LOAD = 8'(IDLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WR_LO,
    ST_WR_HI,
    ST_WAIT
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cnt_zero;
  logic       accept;

  logic [7:0] lcd_d_q, lcd_d_d;
  logic       lcd_rs_q, lcd_rs_d;
  logic       wr_n_q, wr_n_d;
  logic       cs_n_q, cs_n_d;

  assign cnt_zero = (cnt_q == 8'd0);
  assign accept   = phy_valid & phy_ready;

  // Bus outputs are registered from the next state so they line up exactly with the state
  // they belong to and can never glitch.
  assign wr_n_d   = (state_d != ST_WR_LO);
  assign cs_n_d   = (state_d == ST_IDLE);
  assign lcd_d_d  = accept ? phy_data : lcd_d_q;
  assign lcd_rs_d = accept ? phy_rs   : lcd_rs_q;

  // NOTE: the panel bus is visible off-chip, so the data/RS flops are reset too, not just control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      lcd_d_q  <= 8'h00;
      lcd_rs_q <= 1'b0;
      wr_n_q   <= 1'b1;
      cs_n_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lcd_d_q  <= lcd_d_d;
      lcd_rs_q <= lcd_rs_d;
      wr_n_q   <= wr_n_d;
      cs_n_q   <= cs_n_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SETUP;
          cnt_d   = 8'd0;
        end
      end
      ST_SETUP: begin
        state_d = ST_WR_LO;
        cnt_d   = TW_LOAD;
      end
      ST_WR_LO: begin
        if (cnt_zero) begin
          state_d = ST_WR_HI;
          cnt_d   = TH_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_WR_HI: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 8'd1;
        end else if (accept) begin
          state_d = ST_WR_LO;
          cnt_d   = TW_LOAD;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = IDLE_LOAD;
        end
      end
      ST_WAIT: begin
        if (accept) begin
          state_d = ST_WR_LO;
          cnt_d   = TW_LOAD;
        end else if (cnt_zero) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    phy_ready = 1'b0;
    case (state_q)
      ST_IDLE, ST_WAIT: phy_ready = 1'b1;
      ST_WR_HI:         phy_ready = cnt_zero;
      default:          phy_ready = 1'b0;
    endcase
  end

  assign lcd_d    = lcd_d_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_wr_n = wr_n_q;
  assign lcd_cs_n = cs_n_q;

  // Frame mark: 2-flop synchroniser, edge flop, registered strobe. The warm-up count masks the
  // first comparisons after reset so a level already high at release is not seen as an edge.
  logic [1:0] sync_q;
  logic       edge_q;
  logic [1:0] warm_q;
  logic       stb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      edge_q <= 1'b0;
      warm_q <= 2'd0;
      stb_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], lcd_fmark};
      edge_q <= sync_q[1];
      if (warm_q != 2'd3) begin
        warm_q <= warm_q + 2'd1;
      end
      stb_q  <= (warm_q == 2'd3) & sync_q[1] & ~edge_q;
    end
  end

  assign phy_fmark_stb = stb_q;

endmodule

// File: tb/tb_lcd_phy_8080.sv
// Self-checking bench for lcd_phy_8080: directed scenarios plus randomised traffic, scored
// against a timeline model of accept, strobe, chip-select and frame-mark events.
module tb_lcd_phy_8080;

  localparam int TW   = 2;
  localparam int TH   = 2;
  localparam int IDLE = 16;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic [7:0] phy_data  = 8'h00;
  logic       phy_rs    = 1'b0;
  logic       phy_valid = 1'b0;
  logic       lcd_fmark = 1'b0;
  logic       phy_ready;
  logic       phy_fmark_stb;
  logic [7:0] lcd_d;
  logic       lcd_rs;
  logic       lcd_wr_n;
  logic       lcd_cs_n;

  lcd_phy_8080 #(.TW(TW), .TH(TH), .IDLE_CYCLES(IDLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .phy_data     (phy_data),
    .phy_rs       (phy_rs),
    .phy_valid    (phy_valid),
    .phy_ready    (phy_ready),
    .phy_fmark_stb(phy_fmark_stb),
    .lcd_d        (lcd_d),
    .lcd_rs       (lcd_rs),
    .lcd_wr_n     (lcd_wr_n),
    .lcd_cs_n     (lcd_cs_n),
    .lcd_fmark    (lcd_fmark)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         fall;
    int         rise;
    logic [7:0] d;
    logic       rs;
  } wr_t;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       rs;
  } rise_t;

  // Observed events, gathered at the falling clock edge.
  int    obs_wf[$];
  rise_t obs_wr[$];
  int    obs_csf[$];
  int    obs_csr[$];
  int    obs_stb[$];
  // Expected events from the model.
  wr_t   exp_wr[$];
  int    exp_csf[$];
  int    exp_csr[$];
  int    exp_stb[$];

  // Model state: p is the earliest edge at which the next byte can be taken without a setup
  // cycle; accepts up to edge p+IDLE keep chip select low.
  int p      = 0;
  bit have_p = 1'b0;

  logic  prev_wr = 1'b1;
  logic  prev_cs = 1'b1;
  rise_t mon_r;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wr = 1'b1;
      prev_cs = 1'b1;
    end else begin
      if (prev_wr && !lcd_wr_n) obs_wf.push_back(cyc);
      if (!prev_wr && lcd_wr_n) begin
        mon_r.cyc = cyc;
        mon_r.d   = lcd_d;
        mon_r.rs  = lcd_rs;
        obs_wr.push_back(mon_r);
      end
      if (prev_cs && !lcd_cs_n) obs_csf.push_back(cyc);
      if (!prev_cs && lcd_cs_n) obs_csr.push_back(cyc);
      if (phy_fmark_stb) obs_stb.push_back(cyc);
      prev_wr = lcd_wr_n;
      prev_cs = lcd_cs_n;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic rs);
    int  o, a, w;
    bit  setup;
    wr_t e;
    o = cyc + 1;
    if (!have_p) begin
      a = o; setup = 1'b1;
    end else if (o <= p) begin
      a = p; setup = 1'b0;
    end else if (o <= p + IDLE) begin
      a = o; setup = 1'b0;
    end else begin
      a = o; setup = 1'b1;
      exp_csr.push_back(p + IDLE);
    end
    if (setup) exp_csf.push_back(a);
    check("cs_n_before_offer", 32'(lcd_cs_n), 32'(!have_p || cyc >= p + IDLE));
    phy_data  = d;
    phy_rs    = rs;
    phy_valid = 1'b1;
    w = 0;
    while (!phy_ready && w < 64) begin
      tick();
      w++;
    end
    check("accept_edge", cyc + 1, a);
    tick();
    phy_valid = 1'b0;
    phy_data  = ~d;
    phy_rs    = ~rs;
    e.fall = a + 32'(setup);
    e.rise = a + 32'(setup) + TW;
    e.d    = d;
    e.rs   = rs;
    exp_wr.push_back(e);
    p      = a + 32'(setup) + TW + TH;
    have_p = 1'b1;
  endtask

  task automatic settle();
    if (have_p) begin
      while (cyc < p + IDLE + 3) tick();
      exp_csr.push_back(p + IDLE);
      have_p = 1'b0;
    end
    tick(4);
  endtask

  task automatic compare_all();
    check("wr_fall_count", obs_wf.size(), exp_wr.size());
    check("wr_rise_count", obs_wr.size(), exp_wr.size());
    check("cs_fall_count", obs_csf.size(), exp_csf.size());
    check("cs_rise_count", obs_csr.size(), exp_csr.size());
    check("stb_count", obs_stb.size(), exp_stb.size());
    foreach (exp_wr[i]) begin
      if (i < obs_wf.size()) check("wr_fall_cycle", obs_wf[i], exp_wr[i].fall);
      if (i < obs_wr.size()) begin
        check("wr_rise_cycle", obs_wr[i].cyc, exp_wr[i].rise);
        check("lcd_d_at_rise", 32'(obs_wr[i].d), 32'(exp_wr[i].d));
        check("lcd_rs_at_rise", 32'(obs_wr[i].rs), 32'(exp_wr[i].rs));
      end
    end
    foreach (exp_csf[i]) if (i < obs_csf.size()) check("cs_fall_cycle", obs_csf[i], exp_csf[i]);
    foreach (exp_csr[i]) if (i < obs_csr.size()) check("cs_rise_cycle", obs_csr[i], exp_csr[i]);
    foreach (exp_stb[i]) if (i < obs_stb.size()) check("stb_cycle", obs_stb[i], exp_stb[i]);
    obs_wf.delete(); obs_wr.delete(); obs_csf.delete(); obs_csr.delete(); obs_stb.delete();
    exp_wr.delete(); exp_csf.delete(); exp_csr.delete(); exp_stb.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(phy_ready), 32'd1);
    check({tag, "_wr_n"}, 32'(lcd_wr_n), 32'd1);
    check({tag, "_cs_n"}, 32'(lcd_cs_n), 32'd1);
    check({tag, "_lcd_d"}, 32'(lcd_d), 32'h00);
    check({tag, "_lcd_rs"}, 32'(lcd_rs), 32'd0);
    check({tag, "_stb"}, 32'(phy_fmark_stb), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a_abort;

    // Reset state, during and after reset.
    tick(2);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    tick(2);
    check_reset_outputs("after_reset");

    // Single command byte from idle, then full idle timeout.
    send_byte(8'h2A, 1'b0);
    settle();
    compare_all();

    // Burst with valid held: one command then three data bytes.
    send_byte(8'h2C, 1'b0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    settle();
    compare_all();

    // Second byte offered five cycles into the wait window.
    send_byte(8'h44, 1'b1);
    while (cyc < p + 5) tick();
    send_byte(8'h55, 1'b1);
    // Boundary: offer in the last wait cycle (no setup), then one cycle past it (setup).
    while (cyc < p + IDLE - 1) tick();
    send_byte(8'h56, 1'b0);
    while (cyc < p + IDLE) tick();
    send_byte(8'h57, 1'b1);
    // Timeout well past the window.
    while (cyc < p + IDLE + 2) tick();
    send_byte(8'h58, 1'b0);
    settle();
    compare_all();

    // Frame mark: a 10-cycle pulse gives one strobe.
    exp_stb.push_back(cyc + 3);
    lcd_fmark = 1'b1;
    tick(10);
    lcd_fmark = 1'b0;
    tick(8);
    compare_all();

    // Randomised writes (with ignored valid blips while busy) alongside random frame marks.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          int g;
          g = $urandom_range(0, 24);
          tick(g);
          send_byte(8'($urandom), 1'($urandom));
          if ($urandom_range(0, 1) == 1) begin
            phy_data  = 8'hA5;
            phy_valid = 1'b1;
            tick();
            phy_valid = 1'b0;
          end
        end
      end
      begin
        for (int j = 0; j < 12; j++) begin
          int h, l;
          h = $urandom_range(1, 6);
          l = $urandom_range(1, 6);
          exp_stb.push_back(cyc + 3);
          lcd_fmark = 1'b1;
          tick(h);
          lcd_fmark = 1'b0;
          tick(l);
        end
      end
    join
    settle();
    tick(4);
    compare_all();

    // Frame mark already high when reset is released: no strobe, later edges still detected.
    lcd_fmark = 1'b1;
    tick(2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("fmark_reset");
    tick(2);
    rst_n = 1'b1;
    have_p = 1'b0;
    tick(12);
    lcd_fmark = 1'b0;
    tick(4);
    exp_stb.push_back(cyc + 3);
    lcd_fmark = 1'b1;
    tick(5);
    lcd_fmark = 1'b0;
    tick(6);
    compare_all();

    // Reset during the write-low phase aborts the byte.
    send_byte(8'h5A, 1'b1);
    a_abort = cyc;
    exp_wr.delete();
    tick();
    check("wr_n_low_before_abort", 32'(lcd_wr_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_wr_n", 32'(lcd_wr_n), 32'd1);
    check("abort_cs_n", 32'(lcd_cs_n), 32'd1);
    check("abort_ready", 32'(phy_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    have_p = 1'b0;
    exp_csr.push_back(a_abort + 1);
    #1;
    check("post_abort_ready", 32'(phy_ready), 32'd1);
    check("post_abort_lcd_d", 32'(lcd_d), 32'h00);
    tick(12);
    check("post_abort_wr_n", 32'(lcd_wr_n), 32'd1);
    compare_all();

    // Normal operation resumes after the abort.
    send_byte(8'h77, 1'b0);
    settle();
    compare_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
